// File: rtl/core_types_pkg.sv
// Shared fetch-stage types and constants.
package core_types_pkg;

   localparam int unsigned N_BITS = 32;

   typedef enum logic {BOOT, FETCH} fetch_state_e;

   typedef struct packed {
      logic              epoch;
      logic [N_BITS-1:0] pc;
   } fetch_tag_t;

   // Sequential fetch address; wraps modulo 2^N_BITS.
   function automatic logic [N_BITS-1:0] next_pc(input logic [N_BITS-1:0] pc);
      return pc + N_BITS'(4);
   endfunction

endpackage

// File: rtl/f_fetch_fifo.sv
// Synchronous FIFO with flush; used for the in-flight tag queue and the response buffer.
module f_fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Flush discards contents and wins over any same-cycle pop.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/f_fetch_ctrl.sv
// Fetch controller: PC sequencing, credit-limited imem requests, epoch-based
// squash of wrong-path responses and an in-order response buffer to decode.
module f_fetch_ctrl
   import core_types_pkg::*;
#(
   parameter int unsigned       DEPTH  = 2,
   parameter logic [N_BITS-1:0] RST_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jal_vld,
   input  logic [N_BITS-1:0] jal_tgt,
   input  logic              branch_vld,
   input  logic [N_BITS-1:0] branch_tgt,
   input  logic              jalr_vld,
   input  logic [N_BITS-1:0] jalr_tgt,
   input  logic              stall_in,
   output logic              imem_req_vld,
   input  logic              imem_req_rdy,
   output logic [N_BITS-1:0] imem_req_addr,
   input  logic              imem_resp_vld,
   input  logic [N_BITS-1:0] imem_resp_data,
   output logic              inst_vld,
   output logic [N_BITS-1:0] inst,
   output logic [N_BITS-1:0] inst_pc,
   output logic              stall
);

   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned SW    = CW + 1;
   localparam int unsigned BUF_W = 2 * N_BITS;

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic [N_BITS-1:0] fetch_pc;
   logic [N_BITS-1:0] fetch_pc_nxt;
   logic              epoch;
   logic              epoch_nxt;
   logic              redirect;
   logic [N_BITS-1:0] redirect_tgt;
   logic              accept;
   logic              resp_take;
   logic              resp_keep;
   logic              inst_pop;
   fetch_tag_t        tag_in;
   fetch_tag_t        tag_head;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     buf_count;
   logic              tag_full;
   logic              tag_empty;
   logic              buf_full;
   logic              buf_empty;
   logic [BUF_W-1:0]  buf_in;
   logic [BUF_W-1:0]  buf_head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= BOOT;
         fetch_pc <= RST_PC;
         epoch    <= 1'b0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         epoch    <= epoch_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      imem_req_vld  = 1'b0;
      redirect      = jalr_vld || branch_vld || jal_vld;
      redirect_tgt  = jal_tgt;
      unique case (state)
         BOOT:  state_nxt = FETCH;
         FETCH: imem_req_vld = ((SW'(inflight) + SW'(buf_count)) < SW'(DEPTH)) && !tag_full;
         default: state_nxt = BOOT;
      endcase
      if (jalr_vld)        redirect_tgt = jalr_tgt;
      else if (branch_vld) redirect_tgt = branch_tgt;
      stall         = !imem_req_vld || (state == BOOT);
      imem_req_addr = redirect ? redirect_tgt : fetch_pc;
      accept        = imem_req_vld && imem_req_rdy;
      epoch_nxt     = epoch ^ redirect;
      // Without accept this holds fetch_pc or latches the redirect target.
      fetch_pc_nxt  = accept ? next_pc(imem_req_addr) : imem_req_addr;
      tag_in.epoch  = epoch_nxt;
      tag_in.pc     = imem_req_addr;
      resp_take     = imem_resp_vld && !tag_empty;
      resp_keep     = resp_take && !redirect && !buf_full && (tag_head.epoch == epoch_nxt);
      buf_in        = {tag_head.pc, imem_resp_data};
      inst_vld      = !buf_empty;
      inst_pop      = inst_vld && !stall_in;
      inst          = inst_vld ? buf_head[N_BITS-1:0] : '0;
      inst_pc       = inst_vld ? buf_head[BUF_W-1:N_BITS] : '0;
   end

   f_fetch_fifo #(
      .WIDTH ($bits(fetch_tag_t)),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (tag_in),
      .pop       (resp_take),
      .flush     (1'b0),
      .head      (tag_head),
      .count     (inflight),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   f_fetch_fifo #(
      .WIDTH (BUF_W),
      .DEPTH (DEPTH)
   ) u_resp_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_keep),
      .push_data (buf_in),
      .pop       (inst_pop),
      .flush     (redirect),
      .head      (buf_head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   // A response with nothing outstanding is a memory-side protocol error.
   a_resp_has_tag: assert property (@(posedge clk) disable iff (rst) imem_resp_vld |-> !tag_empty);

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Directed bench for f_fetch_ctrl: cycle table plus redirect/reset sequences.
module tb_f_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jal_vld = 1'b0;
   logic [31:0] jal_tgt = '0;
   logic        branch_vld = 1'b0;
   logic [31:0] branch_tgt = '0;
   logic        jalr_vld = 1'b0;
   logic [31:0] jalr_tgt = '0;
   logic        stall_in = 1'b0;
   logic        imem_req_vld;
   logic        imem_req_rdy = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_vld = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_vld;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        stall;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   bit          mem_auto = 1'b1;
   logic [31:0] pend[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_inst[$];

   typedef struct {
      logic        si;
      logic        rv;
      logic [31:0] addr;
      logic        st;
      logic        iv;
      logic [31:0] pc;
   } vec_t;

   vec_t tv[15];

   f_fetch_ctrl #(
      .DEPTH  (2),
      .RST_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .jal_vld        (jal_vld),
      .jal_tgt        (jal_tgt),
      .branch_vld     (branch_vld),
      .branch_tgt     (branch_tgt),
      .jalr_vld       (jalr_vld),
      .jalr_tgt       (jalr_tgt),
      .stall_in       (stall_in),
      .imem_req_vld   (imem_req_vld),
      .imem_req_rdy   (imem_req_rdy),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_vld  (imem_resp_vld),
      .imem_resp_data (imem_resp_data),
      .inst_vld       (inst_vld),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .stall          (stall)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic vec_t v(input logic si, input logic rv, input logic [31:0] addr,
                              input logic st, input logic iv, input logic [31:0] pc);
      vec_t r;
      r.si = si; r.rv = rv; r.addr = addr; r.st = st; r.iv = iv; r.pc = pc;
      return r;
   endfunction

   function automatic logic [31:0] qat(input logic [31:0] q[$], input int unsigned i);
      return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Advance one cycle; the memory model answers in order, one cycle after acceptance.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      #1;
      acc = imem_req_vld && imem_req_rdy;
      a   = imem_req_addr;
      if (inst_vld && !stall_in && !(jal_vld || branch_vld || jalr_vld)) begin
         got_pc.push_back(inst_pc);
         got_inst.push_back(inst);
      end
      @(posedge clk);
      #1;
      if (acc && !rst) pend.push_back(a);
      if (mem_auto && pend.size() > 0) begin
         imem_resp_vld  = 1'b1;
         imem_resp_data = mk(pend.pop_front());
      end else begin
         imem_resp_vld  = 1'b0;
         imem_resp_data = '0;
      end
      jal_vld = 1'b0; branch_vld = 1'b0; jalr_vld = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_resp_vld = 1'b0;
      jal_vld = 1'b0; branch_vld = 1'b0; jalr_vld = 1'b0;
      pend.delete(); got_pc.delete(); got_inst.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_got(input int unsigned n, input string name);
      int unsigned budget = 0;
      while (got_pc.size() < n && budget < 40) begin
         tick();
         budget++;
      end
      n_chk++;
      if (got_pc.size() < n) begin
         n_err++;
         $display("FAIL %s timeout: got %0d instructions required %0d", name, got_pc.size(), n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //          si  rv  addr  st  iv  pc
      tv[0]  = v(0, 0, 32'h00, 1, 0, 32'h00);
      tv[1]  = v(0, 1, 32'h00, 0, 0, 32'h00);
      tv[2]  = v(0, 1, 32'h04, 0, 0, 32'h00);
      tv[3]  = v(0, 0, 32'h08, 1, 1, 32'h00);
      tv[4]  = v(0, 1, 32'h08, 0, 1, 32'h04);
      tv[5]  = v(0, 1, 32'h0c, 0, 0, 32'h00);
      tv[6]  = v(0, 0, 32'h10, 1, 1, 32'h08);
      tv[7]  = v(1, 1, 32'h10, 0, 1, 32'h0c);
      tv[8]  = v(1, 0, 32'h14, 1, 1, 32'h0c);
      tv[9]  = v(1, 0, 32'h14, 1, 1, 32'h0c);
      tv[10] = v(1, 0, 32'h14, 1, 1, 32'h0c);
      tv[11] = v(1, 0, 32'h14, 1, 1, 32'h0c);
      tv[12] = v(0, 0, 32'h14, 1, 1, 32'h0c);
      tv[13] = v(0, 1, 32'h14, 0, 1, 32'h10);
      tv[14] = v(0, 1, 32'h18, 0, 0, 32'h00);

      // Reset values while rst is held.
      #2;
      chk("rst req_vld", {31'b0, imem_req_vld}, 32'd0);
      chk("rst inst_vld", {31'b0, inst_vld}, 32'd0);
      chk("rst stall", {31'b0, stall}, 32'd1);
      chk("rst inst", inst, 32'd0);
      chk("rst inst_pc", inst_pc, 32'd0);

      // Streaming with 1-cycle memory, then decode backpressure.
      mem_auto = 1'b1;
      do_reset();
      for (int i = 0; i < 15; i++) begin
         stall_in = tv[i].si;
         imem_req_rdy = 1'b1;
         #1;
         chk($sformatf("vec%0d req_vld", i), {31'b0, imem_req_vld}, {31'b0, tv[i].rv});
         chk($sformatf("vec%0d req_addr", i), imem_req_addr, tv[i].addr);
         chk($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, tv[i].st});
         chk($sformatf("vec%0d inst_vld", i), {31'b0, inst_vld}, {31'b0, tv[i].iv});
         if (tv[i].iv) begin
            chk($sformatf("vec%0d inst_pc", i), inst_pc, tv[i].pc);
            chk($sformatf("vec%0d inst", i), inst, mk(tv[i].pc));
         end
         tick();
      end
      stall_in = 1'b0;

      // Squash of two in-flight wrong-path requests (0x8, 0xc) by a branch.
      mem_auto = 1'b0;
      do_reset();
      tick();
      jal_vld = 1'b1; jal_tgt = 32'h8;
      #1;
      chk("jal bypass addr", imem_req_addr, 32'h8);
      tick();
      #1;
      chk("after jal addr", imem_req_addr, 32'hc);
      chk("after jal req_vld", {31'b0, imem_req_vld}, 32'd1);
      tick();
      branch_vld = 1'b1; branch_tgt = 32'h100;
      imem_resp_vld = 1'b1;
      imem_resp_data = mk(pend.pop_front());
      #1;
      chk("branch bypass addr", imem_req_addr, 32'h100);
      chk("branch credit req_vld", {31'b0, imem_req_vld}, 32'd0);
      mem_auto = 1'b1;
      tick();
      #1;
      chk("post-branch req_vld", {31'b0, imem_req_vld}, 32'd1);
      chk("post-branch addr", imem_req_addr, 32'h100);
      chk("post-branch inst_vld", {31'b0, inst_vld}, 32'd0);
      wait_got(2, "branch stream");
      chk("branch first pc", qat(got_pc, 0), 32'h100);
      chk("branch first inst", qat(got_inst, 0), mk(32'h100));
      chk("branch second pc", qat(got_pc, 1), 32'h104);

      // Simultaneous redirects: jalr wins.
      got_pc.delete(); got_inst.delete();
      jal_vld = 1'b1; jal_tgt = 32'h20;
      branch_vld = 1'b1; branch_tgt = 32'h40;
      jalr_vld = 1'b1; jalr_tgt = 32'h80;
      #1;
      chk("priority addr", imem_req_addr, 32'h80);
      tick();
      wait_got(2, "priority stream");
      chk("priority first pc", qat(got_pc, 0), 32'h80);
      chk("priority second pc", qat(got_pc, 1), 32'h84);

      // Address wrap at the top of the space.
      got_pc.delete(); got_inst.delete();
      jalr_vld = 1'b1; jalr_tgt = 32'hffff_fffc;
      tick();
      wait_got(2, "wrap stream");
      chk("wrap first pc", qat(got_pc, 0), 32'hffff_fffc);
      chk("wrap second pc", qat(got_pc, 1), 32'h0);
      chk("wrap second inst", qat(got_inst, 1), mk(32'h0));

      // Memory not ready: address held until accepted.
      mem_auto = 1'b1;
      do_reset();
      tick();
      #1;
      chk("rdy first addr", imem_req_addr, 32'h0);
      tick();
      imem_req_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("rdy low%0d addr", i), imem_req_addr, 32'h4);
         chk($sformatf("rdy low%0d req_vld", i), {31'b0, imem_req_vld}, 32'd1);
         tick();
      end
      imem_req_rdy = 1'b1;
      tick();
      #1;
      chk("rdy resume addr", imem_req_addr, 32'h8);
      wait_got(2, "rdy stream");
      chk("rdy first pc", qat(got_pc, 0), 32'h0);
      chk("rdy second pc", qat(got_pc, 1), 32'h4);

      // Asynchronous reset mid-stream with late responses during reset.
      mem_auto = 1'b1;
      stall_in = 1'b1;
      do_reset();
      repeat (3) tick();
      #1;
      chk("pre-rst inst_vld", {31'b0, inst_vld}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async rst req_vld", {31'b0, imem_req_vld}, 32'd0);
      chk("async rst inst_vld", {31'b0, inst_vld}, 32'd0);
      chk("async rst stall", {31'b0, stall}, 32'd1);
      chk("async rst inst", inst, 32'd0);
      chk("async rst inst_pc", inst_pc, 32'd0);
      pend.delete();
      mem_auto = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         imem_resp_vld = 1'b1;
         imem_resp_data = 32'hdead_beef;
      end
      tick();
      imem_resp_vld = 1'b0;
      rst = 1'b0;
      stall_in = 1'b0;
      mem_auto = 1'b1;
      got_pc.delete(); got_inst.delete();
      wait_got(1, "post-rst stream");
      chk("post-rst first pc", qat(got_pc, 0), 32'h0);
      chk("post-rst first inst", qat(got_inst, 0), mk(32'h0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
